vga_pattern_gen: RTL

//  Parametrised VGA timing and test-pattern generator; successor to the fixed 640x480, 1-bit-per-colour peripheral.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_pattern_gen_if.sv | 24 ++
 rtl/vga_timing.sv | 78 +++++++
 rtl/vga_pattern_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: default 640x480@60 timing,
// pattern mode encodings and {r,g,b} bit positions.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int RGB_R = 2;
    localparam int RGB_G = 1;
    localparam int RGB_B = 0;

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    function automatic logic [2:0] checker_rgb(input logic h_bit, input logic v_bit);
        return (h_bit ^ v_bit) ? 3'b111 : 3'b000;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pattern-select inputs and RGB/sync outputs of the VGA pattern generator.
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 1
);
    logic [1:0]            mode;
    logic [2:0]            solid_rgb;
    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] green;
    logic [COLOR_BITS-1:0] blue;
    logic                  h_sync;
    logic                  v_sync;
    logic                  active;
    logic                  frame_start;

    modport master (
        input  mode, solid_rgb,
        output red, green, blue, h_sync, v_sync, active, frame_start
    );

    modport slave (
        output mode, solid_rgb,
        input  red, green, blue, h_sync, v_sync, active, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with combinational sync, visibility and
// frame-start flags decoded from the current counter state.
module vga_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    output logic h_wrap_s,
    output logic h_b5_s,
    output logic v_b5_s,
    output logic h_sync_s,
    output logic v_sync_s,
    output logic vis_s,
    output logic frame_start_s
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [31:0] H_VIS_END  = 32'(H_ACTIVE);
    localparam logic [31:0] HS_START   = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END     = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_VIS_END  = 32'(V_ACTIVE);
    localparam logic [31:0] VS_START   = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END     = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] h_cnt_r;
    logic [V_W-1:0] v_cnt_r;
    logic [31:0]    h_pos_s;
    logic [31:0]    v_pos_s;
    logic           v_wrap_s;

    assign h_pos_s  = 32'(h_cnt_r);
    assign v_pos_s  = 32'(v_cnt_r);
    assign h_wrap_s = (h_cnt_r == H_W'(H_TOTAL - 1));
    assign v_wrap_s = (v_cnt_r == V_W'(V_TOTAL - 1));

    // Raster position: pixel counter wraps per line, line counter advances on that wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (h_wrap_s) begin
            h_cnt_r <= '0;
            v_cnt_r <= v_wrap_s ? '0 : v_cnt_r + V_W'(1);
        end else begin
            h_cnt_r <= h_cnt_r + H_W'(1);
        end
    end

    assign h_sync_s = ((h_pos_s >= HS_START) && (h_pos_s < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign v_sync_s = ((v_pos_s >= VS_START) && (v_pos_s < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vis_s         = (h_pos_s < H_VIS_END) && (v_pos_s < V_VIS_END);
    assign frame_start_s = (h_cnt_r == H_W'(0)) && (v_cnt_r == V_W'(0));

    // Bit 5 of each counter selects the 32x32 checker cell; narrow counters never reach it.
    if (H_W > 5) begin : g_h_b5
        assign h_b5_s = h_cnt_r[5];
    end else begin : g_h_b5_none
        assign h_b5_s = 1'b0;
    end

    if (V_W > 5) begin : g_v_b5
        assign v_b5_s = v_cnt_r[5];
    end else begin : g_v_b5_none
        assign v_b5_s = 1'b0;
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator (solid, bars, checker, scrolling bars).
// Define VGA_OUTPUT_REG_EN for one extra aligned output register stage (latency 2 instead of 1).
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = H_ACTIVE_DEF,
    parameter int   H_FP       = H_FP_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BP       = H_BP_DEF,
    parameter int   V_ACTIVE   = V_ACTIVE_DEF,
    parameter int   V_FP       = V_FP_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BP       = V_BP_DEF,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   COLOR_BITS = 1
) (
    input logic               CLK,
    input logic               RST,
    vga_pattern_gen_if.master bus
);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BP_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    if ((H_ACTIVE % 8) != 0) begin : g_bad_h_active
        $error("vga_pattern_gen: H_ACTIVE must be divisible by 8");
    end

    logic h_wrap_s, h_b5_s, v_b5_s, h_sync_s, v_sync_s, vis_s, frame_start_s;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_timing (
        .CLK          (CLK),
        .RST          (RST),
        .h_wrap_s     (h_wrap_s),
        .h_b5_s       (h_b5_s),
        .v_b5_s       (v_b5_s),
        .h_sync_s     (h_sync_s),
        .v_sync_s     (v_sync_s),
        .vis_s        (vis_s),
        .frame_start_s(frame_start_s)
    );

    mode_e           mode_q_r;
    logic [2:0]      rgb_q_r;
    logic [7:0]      frame_cnt_r;
    logic [7:0]      frame_next_s;
    mode_e           mode_s;
    logic [2:0]      rgb_s;
    logic [2:0]      scroll_off_s;
    logic [BP_W-1:0] bar_px_r;
    logic [2:0]      bar_idx_r;
    logic [2:0]      pix_s;
    logic [2:0]      pix_vis_s;

    // Pixel (0,0) already uses the freshly sampled settings, so the whole frame is consistent.
    assign frame_next_s = frame_cnt_r + 8'd1;
    assign mode_s       = frame_start_s ? mode_e'(bus.mode) : mode_q_r;
    assign rgb_s        = frame_start_s ? bus.solid_rgb : rgb_q_r;
    assign scroll_off_s = frame_start_s ? frame_next_s[7:5] : frame_cnt_r[7:5];

    // Frame-boundary capture of pattern controls and frame counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q_r    <= MODE_SOLID;
            rgb_q_r     <= 3'b000;
            frame_cnt_r <= 8'd0;
        end else if (frame_start_s) begin
            mode_q_r    <= mode_e'(bus.mode);
            rgb_q_r     <= bus.solid_rgb;
            frame_cnt_r <= frame_next_s;
        end else begin
            mode_q_r    <= mode_q_r;
            rgb_q_r     <= rgb_q_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Bar index tracks h_cnt by counting BAR_W pixels per bar, restarting with each line.
    always_ff @(posedge CLK) begin
        if (RST || h_wrap_s) begin
            bar_px_r  <= '0;
            bar_idx_r <= 3'd0;
        end else if (bar_px_r == BP_W'(BAR_W - 1)) begin
            bar_px_r  <= '0;
            bar_idx_r <= bar_idx_r + 3'd1;
        end else begin
            bar_px_r  <= bar_px_r + BP_W'(1);
            bar_idx_r <= bar_idx_r;
        end
    end

    // Pattern select for the pixel at the current counter position.
    always_comb begin
        pix_s = 3'b000;
        case (mode_s)
            MODE_SOLID:  pix_s = rgb_s;
            MODE_BARS:   pix_s = bar_idx_r;
            MODE_CHECK:  pix_s = checker_rgb(h_b5_s, v_b5_s);
            MODE_SCROLL: pix_s = bar_idx_r + scroll_off_s;
            default:     pix_s = 3'b000;
        endcase
    end

    assign pix_vis_s = vis_s ? pix_s : 3'b000;

    logic [COLOR_BITS-1:0] red_r, green_r, blue_r;
    logic                  h_sync_r, v_sync_r, active_r, frame_start_r;

    // First output stage: one clock behind the counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            red_r         <= '0;
            green_r       <= '0;
            blue_r        <= '0;
            h_sync_r      <= ~SYNC_POL;
            v_sync_r      <= ~SYNC_POL;
            active_r      <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            red_r         <= {COLOR_BITS{pix_vis_s[RGB_R]}};
            green_r       <= {COLOR_BITS{pix_vis_s[RGB_G]}};
            blue_r        <= {COLOR_BITS{pix_vis_s[RGB_B]}};
            h_sync_r      <= h_sync_s;
            v_sync_r      <= v_sync_s;
            active_r      <= vis_s;
            frame_start_r <= frame_start_s;
        end
    end

`ifdef VGA_OUTPUT_REG_EN
    logic [COLOR_BITS-1:0] red_d_r, green_d_r, blue_d_r;
    logic                  h_sync_d_r, v_sync_d_r, active_d_r, frame_start_d_r;

    // Second output stage for IO timing; every output is delayed together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            red_d_r         <= '0;
            green_d_r       <= '0;
            blue_d_r        <= '0;
            h_sync_d_r      <= ~SYNC_POL;
            v_sync_d_r      <= ~SYNC_POL;
            active_d_r      <= 1'b0;
            frame_start_d_r <= 1'b0;
        end else begin
            red_d_r         <= red_r;
            green_d_r       <= green_r;
            blue_d_r        <= blue_r;
            h_sync_d_r      <= h_sync_r;
            v_sync_d_r      <= v_sync_r;
            active_d_r      <= active_r;
            frame_start_d_r <= frame_start_r;
        end
    end

    assign bus.red         = red_d_r;
    assign bus.green       = green_d_r;
    assign bus.blue        = blue_d_r;
    assign bus.h_sync      = h_sync_d_r;
    assign bus.v_sync      = v_sync_d_r;
    assign bus.active      = active_d_r;
    assign bus.frame_start = frame_start_d_r;
`else
    assign bus.red         = red_r;
    assign bus.green       = green_r;
    assign bus.blue        = blue_r;
    assign bus.h_sync      = h_sync_r;
    assign bus.v_sync      = v_sync_r;
    assign bus.active      = active_r;
    assign bus.frame_start = frame_start_r;
`endif

endmodule
